// File: rtl/aes_cbc_ctrl_if.sv
// Block stream bundle for the AES chaining controller: input block stream
// and buffered result stream.
interface aes_cbc_ctrl_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         in_sof;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         out_last;

  // Controller side
  modport slave (
    input  in_valid, in_data, in_sof, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  // Block source / result sink side
  modport master (
    output in_valid, in_data, in_sof, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/aes_cbc_ctrl.sv
// ECB/CBC chaining controller in front of a 128-bit AES core: one block in
// flight, one core load per block, result held until consumed.
module aes_cbc_ctrl #(
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 16
) (
  input  logic             mclk,
  input  logic             rst,
  input  logic             cfg_mode,
  input  logic             cfg_dir,
  input  logic [127:0]     cfg_iv,
  input  logic [127:0]     cfg_key,
  input  logic             err_clr,
  aes_cbc_ctrl_if.slave    blk,
  output logic             aes_ld,
  output logic [127:0]     aes_key,
  output logic [127:0]     aes_text_in,
  input  logic             aes_done,
  input  logic [127:0]     aes_text_out,
  output logic [CNT_W-1:0] blk_cnt,
  output logic             busy,
  output logic             err_timeout
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t             state_reg, state_next;
  logic [127:0]       save_reg, save_next;
  logic [127:0]       chain_reg, chain_next;
  logic [127:0]       text_reg, text_next;
  logic [127:0]       out_data_reg, out_data_next;
  logic               last_reg, last_next;
  logic               out_valid_reg, out_valid_next;
  logic               out_last_reg, out_last_next;
  logic               mode_reg, mode_next;
  logic               dir_reg, dir_next;
  logic               err_reg, err_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [TMO_W-1:0]   tmo_reg, tmo_next;

  // Mode/direction/chain seen by the block being accepted: a new message
  // takes them straight from the config inputs.
  logic               mode_eff, dir_eff;
  logic [127:0]       chain_sel;
  logic               err_set;

  assign mode_eff  = blk.in_sof ? cfg_mode : mode_reg;
  assign dir_eff   = blk.in_sof ? cfg_dir  : dir_reg;
  assign chain_sel = blk.in_sof ? cfg_iv   : chain_reg;

  always_comb begin
    state_next     = state_reg;
    save_next      = save_reg;
    chain_next     = chain_reg;
    text_next      = text_reg;
    out_data_next  = out_data_reg;
    last_next      = last_reg;
    out_valid_next = out_valid_reg;
    out_last_next  = out_last_reg;
    mode_next      = mode_reg;
    dir_next       = dir_reg;
    cnt_next       = cnt_reg;
    tmo_next       = tmo_reg;
    err_set        = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (blk.in_valid) begin
          save_next = blk.in_data;
          last_next = blk.in_last;
          if (blk.in_sof) begin
            chain_next = cfg_iv;
            cnt_next   = '0;
            mode_next  = cfg_mode;
            dir_next   = cfg_dir;
          end
          text_next  = (mode_eff && !dir_eff) ? (blk.in_data ^ chain_sel) : blk.in_data;
          state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        tmo_next   = '0;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        // A completion in the final allowed cycle still counts as success.
        if (aes_done) begin
          if (!dir_reg) begin
            out_data_next = aes_text_out;
            if (mode_reg) chain_next = aes_text_out;
          end else if (mode_reg) begin
            out_data_next = aes_text_out ^ chain_reg;
            chain_next    = save_reg;
          end else begin
            out_data_next = aes_text_out;
          end
          out_valid_next = 1'b1;
          out_last_next  = last_reg;
          state_next     = S_OUT;
        end else if (tmo_reg == TMO_W'(TIMEOUT_CYC - 1)) begin
          err_set    = 1'b1;
          state_next = S_IDLE;
        end else begin
          tmo_next = tmo_reg + 1'b1;
        end
      end
      S_OUT: begin
        if (blk.out_ready) begin
          out_valid_next = 1'b0;
          cnt_next       = cnt_reg + 1'b1;
          state_next     = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase

    err_next = err_set ? 1'b1 : (err_clr ? 1'b0 : err_reg);
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      save_reg      <= '0;
      chain_reg     <= '0;
      text_reg      <= '0;
      out_data_reg  <= '0;
      last_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      mode_reg      <= 1'b0;
      dir_reg       <= 1'b0;
      err_reg       <= 1'b0;
      cnt_reg       <= '0;
      tmo_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      save_reg      <= save_next;
      chain_reg     <= chain_next;
      text_reg      <= text_next;
      out_data_reg  <= out_data_next;
      last_reg      <= last_next;
      out_valid_reg <= out_valid_next;
      out_last_reg  <= out_last_next;
      mode_reg      <= mode_next;
      dir_reg       <= dir_next;
      err_reg       <= err_next;
      cnt_reg       <= cnt_next;
      tmo_reg       <= tmo_next;
    end
  end

  assign blk.in_ready  = (state_reg == S_IDLE);
  assign blk.out_valid = out_valid_reg;
  assign blk.out_data  = out_data_reg;
  assign blk.out_last  = out_last_reg;
  assign aes_ld        = (state_reg == S_LOAD);
  assign aes_key       = cfg_key;
  assign aes_text_in   = text_reg;
  assign blk_cnt       = cnt_reg;
  assign busy          = (state_reg != S_IDLE);
  assign err_timeout   = err_reg;

endmodule

// File: doc/aes_cbc_ctrl.md
Name: aes_cbc_ctrl

Overview:
Block-chaining controller that sits directly upstream of the 128-bit AES cipher/inverse-cipher cores. It drives their load/done interface.
- Accepts 128-bit blocks on a valid/ready stream.
- Applies ECB or CBC chaining in the encrypt or decrypt direction.
- Sequences one core operation per block and returns the result on a buffered output stream.
- Lets multi-block messages be processed without firmware handling the IV/ciphertext XOR.

Parameters:
TIMEOUT_CYC, 64, cycles allowed in WAIT for aes_done before abort
CNT_W, 16, width of the per-message block counter

Ports:
mclk  input  1  clock
rst  input  1  reset, synchronous, active-high
cfg_mode  input  1  0=ECB, 1=CBC
cfg_dir  input  1  0=encrypt, 1=decrypt
cfg_iv  input  128  initialisation vector, sampled on accept of an in_sof block
cfg_key  input  128  key, passed through to core; must be stable for the whole message
err_clr  input  1  clears err_timeout
in_valid  input  1  input block valid
in_ready  output  1  input block accepted when in_valid&in_ready
in_data  input  128  input block (plaintext for encrypt, ciphertext for decrypt)
in_sof  input  1  first block of message
in_last  input  1  last block of message
aes_ld  output  1  one-cycle load pulse to core
aes_key  output  128  key to core (=cfg_key)
aes_text_in  output  128  block to core
aes_done  input  1  one-cycle completion pulse from core
aes_text_out  input  128  core result, valid while aes_done=1
out_valid  output  1  result valid
out_ready  input  1  result consumed when out_valid&out_ready
out_data  output  128  result block
out_last  output  1  copy of in_last of the corresponding block
blk_cnt  output  CNT_W  blocks output in the current message
busy  output  1  state != IDLE
err_timeout  output  1  sticky core-timeout flag

Behaviour:
Reset values:
- State IDLE; in_ready=1.
- aes_ld, out_valid, out_last, busy and err_timeout are 0; out_data, aes_text_in, blk_cnt, chain and save registers are 0.
- Reset mid-operation abandons the block in flight and its result.
- An aes_done arriving after reset is ignored.

IDLE:
- in_ready=1.
- On accept, latch in_data into save_reg and in_last into last_reg.
- If in_sof=1, load chain_reg with cfg_iv and clear blk_cnt.
- Register aes_text_in:
  - encrypt CBC: in_data ^ chain_next, where chain_next = cfg_iv if in_sof else chain_reg
  - otherwise: in_data
- Go to LOAD.

LOAD:
- aes_ld=1 for exactly this cycle; aes_text_in is stable from here through WAIT.
- Clear the timeout counter; go to WAIT.

WAIT:
- Count cycles while waiting for aes_done.
- On aes_done=1:
  - encrypt: out_data = aes_text_out; in CBC, chain_reg <= aes_text_out.
  - decrypt CBC: out_data = aes_text_out ^ chain_reg; chain_reg <= save_reg.
  - decrypt ECB: out_data = aes_text_out.
  - Set out_valid=1 and out_last=last_reg next cycle; go to OUT.
- If the counter reaches TIMEOUT_CYC with no aes_done: set err_timeout, discard the block, return to IDLE; chain_reg is unchanged.
- A done and a timeout in the same cycle: done wins.

OUT:
- Hold out_data/out_valid stable until out_ready.
- On handshake: out_valid=0 and blk_cnt++ (wraps at 2^CNT_W).
- Then go to IDLE, so in_ready=1 on the following cycle (no bypass).

General rules:
- in_ready=0 in LOAD, WAIT and OUT; one block in flight maximum.
- aes_done in any state other than WAIT is ignored.
- Latency: accept at cycle T → aes_ld at T+1 → aes_done at T+1+N → out_valid at T+2+N.
- err_clr clears err_timeout. If err_clr and a new timeout occur in the same cycle, the set wins.
- cfg_mode and cfg_dir are sampled at in_sof accept and held for the whole message.
- A block accepted without in_sof and with no prior sof since reset uses chain_reg=0.

Test Plan:
1. ECB encrypt: key 2b7e151628aed2a6abf7158809cf4f3c, in_data 6bc1bee22e409f96e93d7e117393172a, sof=last=1 → one aes_ld pulse; out_data 3ad77bb40d7a3660a89ecaf32466ef97, out_last=1, blk_cnt=1.
2. CBC encrypt, 2 blocks: IV 000102030405060708090a0b0c0d0e0f, P1 as in 1, P2 ae2d8a571e03ac9c9eb76fac45af8e51 → outputs 7649abac8119b246cee98e9b12e9197d, then 5086cb9b507219ee95db113a917678b2 (out_last on the second only); blk_cnt=2.
3. CBC decrypt of the two ciphertexts from 2, same IV → outputs P1 then P2 exactly. Second message with new in_sof restarts from IV and blk_cnt returns to 1.
4. Backpressure: hold out_ready=0 for 20 cycles → out_data stable, in_ready=0, no extra aes_ld. Release → single handshake; in_ready=1 next cycle.
5. Timeout: core model never asserts done → err_timeout=1 after 64 WAIT cycles, state IDLE, no out_valid. A late aes_done is ignored. err_clr clears the flag.
6. Reset mid-WAIT: assert rst for 1 cycle → all outputs at reset values; subsequent aes_done ignored; next CBC message reproduces the vectors from 2.
